// File: rtl/bus_arb_pkg.sv
// Shared types for system-bus arbitration: arbiter FSM states, SYSBUS tag
// fields used by the caches, and the modular index helper for round-robin search.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        SYSBUS_WRITE = 1'b0,
        SYSBUS_READ  = 1'b1
    } sysbus_dir_e;

    typedef enum logic [3:0] {
        SYSBUS_MEMORY = 4'b0001,
        SYSBUS_MMIO   = 4'b0011,
        SYSBUS_PORT   = 4'b0100,
        SYSBUS_IRQ    = 4'b1110
    } sysbus_space_e;

    // (base + off) mod n for base < n and off < n, without a divider.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        if (sum >= n)
            sum = sum - n;
        return sum;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'(wrap_add(32'(rr_ptr), off, NUM_REQ));
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the single system bus port shared by the cache masters;
// the owner's transaction is muxed through while its grant stands.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int GRANT_TIMEOUT  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                m_busreq,
    input  logic [NUM_REQ-1:0]                m_busidle,
    output logic [NUM_REQ-1:0]                m_busgrant,
    input  logic [NUM_REQ-1:0]                m_reqcyc,
    input  logic [NUM_REQ-1:0]                m_respack,
    input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] m_req,
    input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  m_reqtag,
    output logic [NUM_REQ-1:0]                m_reqack,
    output logic [NUM_REQ-1:0]                m_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]         m_resp,
    output logic [BUS_TAG_WIDTH-1:0]          m_resptag,
    output logic                              bus_reqcyc,
    output logic                              bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

    arb_state_e       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [CNT_W-1:0] grant_cnt;
    logic             bus_owned;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (m_busreq),
        .rr_ptr (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Explicit wrap keeps non-power-of-two master counts in range.
    assign rr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            grant_cnt  <= '0;
            m_busgrant <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick_idx;
                        m_busgrant <= NUM_REQ'(1) << pick_idx;
                        grant_cnt  <= '0;
                        state      <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!m_busidle[owner]) begin
                        state <= ARB_BUSY;
                    end else if (grant_cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
                        m_busgrant <= '0;
                        state      <= ARB_RELEASE;
                    end else begin
                        grant_cnt <= grant_cnt + CNT_W'(1);
                    end
                end
                ARB_BUSY: begin
                    if (m_busidle[owner]) begin
                        m_busgrant <= '0;
                        state      <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    rr_ptr <= rr_next;
                    state  <= ARB_IDLE;
                end
                default: begin
                    m_busgrant <= '0;
                    state      <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus_owned = (state == ARB_GRANT) || (state == ARB_BUSY);

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        m_reqack    = '0;
        m_respcyc   = '0;
        if (bus_owned) begin
            bus_reqcyc       = m_reqcyc[owner];
            bus_respack      = m_respack[owner];
            bus_req          = m_req[int'(owner)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            bus_reqtag       = m_reqtag[int'(owner)*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
            m_reqack[owner]  = bus_reqack;
            m_respcyc[owner] = bus_respcyc;
        end
    end

    assign m_resp    = bus_resp;
    assign m_resptag = bus_resptag;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(m_busgrant));

    a_reqcyc_needs_grant: assert property (@(posedge clk) disable iff (reset)
        bus_reqcyc |-> (|m_busgrant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter with three masters: stimulus queues the
// expected grants and bus transfers, a negedge monitor pops and compares them.
module tb_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      m_busreq, m_busidle, m_busgrant, m_reqcyc, m_respack;
    logic [N*DW-1:0]   m_req;
    logic [N*TW-1:0]   m_reqtag;
    logic [N-1:0]      m_reqack, m_respcyc;
    logic [DW-1:0]     m_resp;
    logic [TW-1:0]     m_resptag;
    logic              bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [DW-1:0]     bus_req, bus_resp;
    logic [TW-1:0]     bus_reqtag, bus_resptag;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_REQ(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .GRANT_TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .reset(reset),
        .m_busreq(m_busreq), .m_busidle(m_busidle), .m_busgrant(m_busgrant),
        .m_reqcyc(m_reqcyc), .m_respack(m_respack), .m_req(m_req), .m_reqtag(m_reqtag),
        .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } xfer_t;

    int       exp_grant_q[$];
    xfer_t    exp_xfer_q[$];
    int       vectors = 0;
    int       miscompares = 0;
    int       last_owner = N - 1;
    bit       done = 1'b0;
    logic [N-1:0] mon_prev;
    xfer_t    mon_e;
    int       mon_eg;
    logic [N-1:0] first_rnd;

    function automatic logic [N-1:0] oh(input int k);
        return N'(1) << k;
    endfunction

    // Round-robin rule: first requester strictly after the previous owner, cyclically.
    function automatic int model_pick(input logic [N-1:0] req, input int last);
        int idx;
        for (int s = 1; s <= N; s++) begin
            idx = (last + s) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] r);
        m_busreq = r;
        if (r != '0) exp_grant_q.push_back(model_pick(r, last_owner));
    endtask

    task automatic wait_grant(input int exp_lat);
        int lat;
        lat = 0;
        do begin
            tick;
            lat++;
        end while (m_busgrant == '0 && lat < 40);
        chk("grant_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic run_txn(input int k, input bit timeout, input logic [N-1:0] next_req);
        logic [DW-1:0] d, rsp;
        logic [TW-1:0] t, rt;
        int cnt;
        m_reqcyc = '0;
        for (int j = 0; j < N; j++) begin
            if (j != k) begin
                m_reqcyc[j]         = 1'b1;
                m_req[j*DW +: DW]   = {$urandom, $urandom};
                m_reqtag[j*TW +: TW] = TW'($urandom);
            end
        end
        if (timeout) begin
            cnt = 1;
            while (m_busgrant != '0 && cnt < 40) begin
                tick;
                if (m_busgrant != '0) cnt++;
            end
            chk("timeout_cycles", 64'(cnt), 64'(TO));
            last_owner = k;
            set_req(next_req);
        end else begin
            d = {$urandom, $urandom};
            t = TW'($urandom);
            m_busidle[k]         = 1'b0;
            m_reqcyc[k]          = 1'b1;
            m_req[k*DW +: DW]    = d;
            m_reqtag[k*TW +: TW] = t;
            exp_xfer_q.push_back('{k, d, t});
            bus_reqack = 1'b1;
            #1;
            chk("reqack_route", 64'(m_reqack), 64'(oh(k)));
            tick;
            m_reqcyc[k] = 1'b0;
            bus_reqack  = 1'b0;
            repeat ($urandom_range(0, 2)) tick;
            rsp = {$urandom, $urandom};
            rt  = TW'($urandom);
            bus_respcyc  = 1'b1;
            bus_resp     = rsp;
            bus_resptag  = rt;
            m_respack[k] = 1'b1;
            #1;
            chk("respcyc_route", 64'(m_respcyc), 64'(oh(k)));
            chk("resp_bcast", m_resp, rsp);
            chk("resptag_bcast", 64'(m_resptag), 64'(rt));
            chk("respack_mux", 64'(bus_respack), 64'(1));
            tick;
            bus_respcyc  = 1'b0;
            m_respack[k] = 1'b0;
            m_busidle[k] = 1'b1;
            last_owner   = k;
            set_req(next_req);
            tick;
            chk("release_gap", 64'(m_busgrant), 64'(0));
        end
    endtask

    task automatic run_seq(input logic [N-1:0] first, input int n, input bit rnd,
                           input logic [N-1:0] hold, input int to_pct);
        int k;
        logic [N-1:0] nxt;
        k = model_pick(first, last_owner);
        set_req(first);
        for (int i = 0; i < n; i++) begin
            wait_grant((i == 0) ? 1 : 2);
            if (i == n - 1)  nxt = '0;
            else if (rnd)    nxt = N'($urandom_range(1, (1 << N) - 1));
            else             nxt = hold;
            run_txn(k, ($urandom_range(0, 99) < to_pct), nxt);
            k = model_pick(nxt, last_owner);
        end
        repeat (3) tick;
    endtask

    task automatic do_reset;
        reset       = 1'b1;
        m_busreq    = '0;
        m_busidle   = '1;
        m_reqcyc    = '0;
        m_respack   = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        tick;
        tick;
        reset      = 1'b0;
        last_owner = N - 1;
    endtask

    task automatic reset_mid_burst;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        set_req(3'b001);
        wait_grant(1);
        run_txn(0, 1'b0, 3'b010);
        wait_grant(2);
        d = {$urandom, $urandom};
        t = TW'($urandom);
        m_reqcyc             = '0;
        m_busidle[1]         = 1'b0;
        m_reqcyc[1]          = 1'b1;
        m_req[1*DW +: DW]    = d;
        m_reqtag[1*TW +: TW] = t;
        exp_xfer_q.push_back('{1, d, t});
        tick;
        m_reqcyc[1] = 1'b0;
        tick;
        reset       = 1'b1;
        m_reqcyc[1] = 1'b1;
        m_busreq    = '0;
        tick;
        chk("rst_mid_grant", 64'(m_busgrant), 64'(0));
        chk("rst_mid_reqcyc", 64'(bus_reqcyc), 64'(0));
        chk("rst_mid_req", bus_req, 64'(0));
        reset      = 1'b0;
        m_reqcyc   = '0;
        m_busidle  = '1;
        last_owner = N - 1;
        set_req(3'b011);
        wait_grant(1);
        run_txn(0, 1'b0, '0);
        repeat (3) tick;
    endtask

    initial begin
        m_busreq    = '1;
        m_busidle   = '1;
        m_reqcyc    = '1;
        m_respack   = '1;
        m_req       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m_reqtag    = N*TW'($urandom);
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = '0;
        bus_resptag = '0;
        tick;
        tick;
        chk("rst_grant", 64'(m_busgrant), 64'(0));
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'(0));
        chk("rst_respack", 64'(bus_respack), 64'(0));
        chk("rst_req", bus_req, 64'(0));
        chk("rst_reqtag", 64'(bus_reqtag), 64'(0));
        chk("rst_reqack", 64'(m_reqack), 64'(0));
        chk("rst_respcyc", 64'(m_respcyc), 64'(0));
        do_reset;
        fork
            begin
                run_seq(3'b001, 1, 1'b0, '0, 0);
                do_reset;
                run_seq(3'b011, 4, 1'b0, 3'b011, 0);
                do_reset;
                run_seq(3'b010, 2, 1'b0, 3'b011, 100);
                do_reset;
                reset_mid_burst;
                do_reset;
                run_seq(3'b111, 6, 1'b0, 3'b111, 0);
                first_rnd = N'($urandom_range(1, (1 << N) - 1));
                run_seq(first_rnd, 30, 1'b1, '0, 15);
                repeat (5) tick;
                done = 1'b1;
            end
            begin
                mon_prev = '0;
                while (!done) begin
                    @(negedge clk);
                    if (!reset) begin
                        if (m_busgrant != '0 && mon_prev == '0) begin
                            if (exp_grant_q.size() == 0) begin
                                chk("grant_unexpected", 64'(m_busgrant), 64'(0));
                            end else begin
                                mon_eg = exp_grant_q.pop_front();
                                chk("grant_owner", 64'(m_busgrant), 64'(oh(mon_eg)));
                            end
                        end
                        if (bus_reqcyc) begin
                            if (exp_xfer_q.size() == 0) begin
                                chk("xfer_unexpected", 64'(bus_reqcyc), 64'(0));
                            end else begin
                                mon_e = exp_xfer_q.pop_front();
                                chk("xfer_owner", 64'(m_busgrant), 64'(oh(mon_e.owner)));
                                chk("xfer_req", bus_req, mon_e.data);
                                chk("xfer_tag", 64'(bus_reqtag), 64'(mon_e.tag));
                            end
                        end
                    end
                    mon_prev = m_busgrant;
                end
            end
        join
        chk("grant_q_drained", 64'(exp_grant_q.size()), 64'(0));
        chk("xfer_q_drained", 64'(exp_xfer_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
